// File: rtl/threshold_pkg.sv
// rtl/threshold_pkg.sv - shared types and constants for the threshold sequencer
//
// Purpose: global_state encodings, bus widths and the default per-stage
// timeout used by threshold_sequencer and stage_watchdog.
// Optional feature macro (used by the importing files): SEQ_TIMEOUT_EN.

package threshold_pkg;

  localparam int GLOBAL_STATE_W         = 3;
  localparam int WDOG_W                 = 22;
  localparam int TIMEOUT_CYCLES_DEFAULT = 2097152;

  typedef enum logic [GLOBAL_STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_BOX    = 3'd1,
    ST_THRESH = 3'd2,
    ST_OUTPUT = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd7
  } state_e;

  // States in which a processing stage is running.
  function automatic logic is_run_state(input state_e s);
    return (s == ST_BOX) || (s == ST_THRESH) || (s == ST_OUTPUT);
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// rtl/stage_watchdog.sv - per-stage cycle counter with terminal-count flag
//
// Purpose: counts cycles spent in the current stage and flags the last
// allowed cycle. Instantiated by threshold_sequencer only when
// SEQ_TIMEOUT_EN is defined.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   restart_i   in   clear the count (state entry); wins over count_en_i
//   count_en_i  in   increment this cycle (a stage is running)
//   terminal_o  out  count is at TIMEOUT_CYCLES-1 while counting

module stage_watchdog
  import threshold_pkg::*;
#(
  parameter int CNT_W          = WDOG_W,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic restart_i,
  input  logic count_en_i,
  output logic terminal_o
);

  localparam logic [CNT_W-1:0] TERM_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (restart_i) begin
      count_d = '0;
    end else if (count_en_i) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal_o = count_en_i && (count_q == TERM_COUNT);

endmodule

// File: rtl/threshold_sequencer.sv
// rtl/threshold_sequencer.sv - stage sequencer and result-memory port owner
//
// Purpose: steps the adaptive-thresholding pipeline through box filter,
// threshold and output stages, re-arms the stages with a one-cycle
// active-low clear, and routes the shared result memory port to the
// active stage. Optional stage timeout: define SEQ_TIMEOUT_EN.
// Ports:
//   clock, reset                         clock / async active-high reset
//   start                                run request (IDLE, DONE, ERROR only)
//   global_state                         current state (also the state register)
//   stage_clear_n                        registered stage reset, active low
//   box_finished/thr_finished/out_finished  stage completion levels
//   box_res_col/row/data/wren            box filter write port
//   thr_res_col/row                      threshold read address
//   mem_col/row/data/wren                result memory port
//   busy, done, error                    status

module threshold_sequencer
  import threshold_pkg::*;
#(
  parameter int WIDTH_BITS     = 8,
  parameter int HEIGHT_BITS    = 8,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  output logic [GLOBAL_STATE_W-1:0] global_state,
  output logic                      stage_clear_n,
  input  logic                      box_finished,
  input  logic                      thr_finished,
  input  logic                      out_finished,
  input  logic [WIDTH_BITS-1:0]     box_res_col,
  input  logic [HEIGHT_BITS-1:0]    box_res_row,
  input  logic [7:0]                box_res_data,
  input  logic                      box_res_wren,
  input  logic [WIDTH_BITS-1:0]     thr_res_col,
  input  logic [HEIGHT_BITS-1:0]    thr_res_row,
  output logic [WIDTH_BITS-1:0]     mem_col,
  output logic [HEIGHT_BITS-1:0]    mem_row,
  output logic [7:0]                mem_data,
  output logic                      mem_wren,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  state_e state_q;
  state_e state_d;
  logic   clear_q;
  logic   clear_d;
  logic   stage_timeout;

  // ------------------------------------------------------------------
  // Next-state logic. Only the running stage's flag is looked at, and
  // only once its clear has been released, so flags left high by the
  // previous run (or by an earlier stage) cannot advance the sequence.
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    clear_d = 1'b1;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_BOX;
          clear_d = 1'b0;
        end
      end
      ST_BOX: begin
        if (clear_q && box_finished) begin
          state_d = ST_THRESH;
        end else if (stage_timeout) begin
          state_d = ST_ERROR;
        end
      end
      ST_THRESH: begin
        if (clear_q && thr_finished) begin
          state_d = ST_OUTPUT;
        end else if (stage_timeout) begin
          state_d = ST_ERROR;
        end
      end
      ST_OUTPUT: begin
        if (clear_q && out_finished) begin
          state_d = ST_DONE;
        end else if (stage_timeout) begin
          state_d = ST_ERROR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // clear_q resets low so the stages are held in reset together with
  // the sequencer and released on the first edge afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clear_q <= clear_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  stage_watchdog #(
    .CNT_W         (WDOG_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .restart_i (state_d != state_q),
    .count_en_i(is_run_state(state_q)),
    .terminal_o(stage_timeout)
  );

  assign error = (state_q == ST_ERROR);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign stage_timeout      = 1'b0;
  assign error              = 1'b0;
`endif

  assign global_state  = state_q;
  assign stage_clear_n = clear_q;
  assign busy          = is_run_state(state_q);
  assign done          = (state_q == ST_DONE);

  // ------------------------------------------------------------------
  // Result memory mux. Combinational so the box filter's last write,
  // issued in the same cycle as box_finished, still lands while the
  // registered state is BOX.
  // ------------------------------------------------------------------
  always_comb begin
    mem_col  = '0;
    mem_row  = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    case (state_q)
      ST_BOX: begin
        mem_col  = box_res_col;
        mem_row  = box_res_row;
        mem_data = box_res_data;
        mem_wren = box_res_wren;
      end
      ST_THRESH: begin
        mem_col = thr_res_col;
        mem_row = thr_res_row;
      end
      default: begin
        mem_col  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_threshold_sequencer.sv
// tb/tb_threshold_sequencer.sv - scoreboard bench for threshold_sequencer

module tb_threshold_sequencer;
  import threshold_pkg::*;

  localparam int WB = 8;
  localparam int HB = 8;
`ifdef SEQ_TIMEOUT_EN
  localparam int BL = 10;
  localparam int TL = 5;
  localparam int OL = 7;
`else
  localparam int BL = 40;
  localparam int TL = 20;
  localparam int OL = 30;
`endif

  typedef struct {
    logic [2:0] st;
    int         cyc;
    logic       clr;
  } exp_t;

  logic          clock;
  logic          reset;
  logic          start;
  logic [2:0]    global_state;
  logic          stage_clear_n;
  logic          box_finished;
  logic          thr_finished;
  logic          out_finished;
  logic [WB-1:0] box_res_col;
  logic [HB-1:0] box_res_row;
  logic [7:0]    box_res_data;
  logic          box_res_wren;
  logic [WB-1:0] thr_res_col;
  logic [HB-1:0] thr_res_row;
  logic [WB-1:0] mem_col;
  logic [HB-1:0] mem_row;
  logic [7:0]    mem_data;
  logic          mem_wren;
  logic          busy;
  logic          done;
  logic          error;

  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   box_lat = BL;
  int   thr_lat = TL;
  int   out_lat = OL;
  int   box_cnt = 0;
  int   thr_cnt = 0;
  int   out_cnt = 0;
  exp_t sb[$];
  logic [2:0] prev_st = 3'd0;

  threshold_sequencer #(
    .WIDTH_BITS    (WB),
    .HEIGHT_BITS   (HB),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .global_state (global_state),
    .stage_clear_n(stage_clear_n),
    .box_finished (box_finished),
    .thr_finished (thr_finished),
    .out_finished (out_finished),
    .box_res_col  (box_res_col),
    .box_res_row  (box_res_row),
    .box_res_data (box_res_data),
    .box_res_wren (box_res_wren),
    .thr_res_col  (thr_res_col),
    .thr_res_row  (thr_res_row),
    .mem_col      (mem_col),
    .mem_row      (mem_row),
    .mem_data     (mem_data),
    .mem_wren     (mem_wren),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Stub stages: synchronous, reset by stage_clear_n. A stage raises its
  // finished level in its lat-th active cycle (lat 0 = never) and holds it.
  always @(posedge clock or posedge reset) begin
    if (reset || !stage_clear_n) begin
      box_cnt      <= 0;
      thr_cnt      <= 0;
      out_cnt      <= 0;
      box_finished <= 1'b0;
      thr_finished <= 1'b0;
      out_finished <= 1'b0;
      box_res_wren <= 1'b0;
    end else begin
      box_res_wren <= 1'b0;
      if (global_state == ST_BOX && !box_finished) begin
        box_cnt <= box_cnt + 1;
        if (box_cnt + 1 == box_lat - 1) begin
          box_finished <= 1'b1;
          box_res_wren <= 1'b1;
        end
      end
      if (global_state == ST_THRESH && !thr_finished && thr_lat != 0) begin
        thr_cnt <= thr_cnt + 1;
        if (thr_cnt + 1 == thr_lat - 1) thr_finished <= 1'b1;
      end
      if (global_state == ST_OUTPUT && !out_finished) begin
        out_cnt <= out_cnt + 1;
        if (out_cnt + 1 == out_lat - 1) out_finished <= 1'b1;
      end
    end
  end

  // Monitor: every change of global_state must match the next expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (global_state !== prev_st) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: state %0d at cycle %0d, none expected", global_state, cyc);
        end else begin
          e = sb.pop_front();
          if (global_state !== e.st || cyc != e.cyc || stage_clear_n !== e.clr) begin
            errors++;
            $display("FAIL sb_transition: got state %0d cyc %0d clr %0b, expected state %0d cyc %0d clr %0b",
                     global_state, cyc, stage_clear_n, e.st, e.cyc, e.clr);
          end
        end
        prev_st = global_state;
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int limit, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      #1;
      n++;
    end while (global_state !== st && n < limit);
    check(nm, int'(global_state), int'(st));
  endtask

  task automatic start_run(output int s);
    @(negedge clock);
    start = 1'b1;
    s = cyc + 1;
    sb.push_back('{3'(ST_BOX), s, 1'b0});
    @(negedge clock);
    start = 1'b0;
    #1;
    check("start_clear_low", int'(stage_clear_n), 0);
    check("start_busy", int'(busy), 1);
    check("start_error_low", int'(error), 0);
    @(negedge clock);
    #1;
    check("start_clear_released", int'(stage_clear_n), 1);
  endtask

  task automatic run_full(input bit poke);
    int s;
    int n;
    start_run(s);
    sb.push_back('{3'(ST_THRESH), s + BL + 1, 1'b1});
    sb.push_back('{3'(ST_OUTPUT), s + BL + 1 + TL, 1'b1});
    sb.push_back('{3'(ST_DONE), s + BL + 1 + TL + OL, 1'b1});
    if (poke) begin
      repeat (4) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      #1;
      check("start_in_box_state", int'(global_state), int'(ST_BOX));
      check("start_in_box_clear", int'(stage_clear_n), 1);
    end
    n = 0;
    do begin
      @(negedge clock);
      #1;
      n++;
    end while (!box_finished && n < 200);
    check("last_write_state", int'(global_state), int'(ST_BOX));
    check("last_write_col", int'(mem_col), 3);
    check("last_write_row", int'(mem_row), 3);
    check("last_write_data", int'(mem_data), 8'hA5);
    check("last_write_wren", int'(mem_wren), 1);
    wait_state(ST_THRESH, 10, "enter_thresh");
    check("thr_mux_col", int'(mem_col), 7);
    check("thr_mux_row", int'(mem_row), 9);
    check("thr_mux_data", int'(mem_data), 0);
    check("thr_mux_wren", int'(mem_wren), 0);
    wait_state(ST_OUTPUT, 200, "enter_output");
    check("out_mux_zero", int'({mem_col, mem_row, mem_data, mem_wren}), 0);
    wait_state(ST_DONE, 200, "enter_done");
    check("done_flag", int'(done), 1);
    check("done_busy", int'(busy), 0);
    check("done_error", int'(error), 0);
    check("done_mux_zero", int'({mem_col, mem_row, mem_data, mem_wren}), 0);
  endtask

  initial begin
    int s;
    reset        = 1'b1;
    start        = 1'b0;
    box_res_col  = 8'd3;
    box_res_row  = 8'd3;
    box_res_data = 8'hA5;
    thr_res_col  = 8'd7;
    thr_res_row  = 8'd9;

    #2;
    check("rst_state", int'(global_state), 0);
    check("rst_clear", int'(stage_clear_n), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_mem", int'({mem_col, mem_row, mem_data, mem_wren}), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    #1;
    check("idle_state", int'(global_state), 0);
    check("idle_clear", int'(stage_clear_n), 1);
    check("idle_wren", int'(mem_wren), 0);
    check("idle_done", int'(done), 0);

    run_full(1'b1);
    run_full(1'b0);

    // Reset in the middle of BOX, released before the next clock edge.
    start_run(s);
    repeat (6) @(negedge clock);
    sb.push_back('{3'(ST_IDLE), cyc + 1, 1'b1});
    #1 reset = 1'b1;
    #1;
    check("midrst_state", int'(global_state), 0);
    check("midrst_clear", int'(stage_clear_n), 0);
    check("midrst_busy", int'(busy), 0);
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);

`ifdef SEQ_TIMEOUT_EN
    // Box finishes in the terminal-count cycle (finished wins); threshold never finishes.
    box_lat = 15;
    thr_lat = 0;
    start_run(s);
    sb.push_back('{3'(ST_THRESH), s + 16, 1'b1});
    sb.push_back('{3'(ST_ERROR), s + 32, 1'b1});
    wait_state(ST_THRESH, 40, "tie_thresh");
    wait_state(ST_ERROR, 40, "timeout_error");
    check("timeout_error_flag", int'(error), 1);
    check("timeout_busy", int'(busy), 0);
    start_run(s);
    check("restart_error_low", int'(error), 0);
`endif

    repeat (2) @(negedge clock);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/threshold_sequencer.md
# threshold_sequencer

Top-level controller for the adaptive-thresholding pipeline. It drives the 3-bit `global_state` bus that enables each processing stage in turn: box filter, threshold, output. It re-arms the stages through a shared active-low stage reset. It also owns the single write/read port of the shared average (result) memory, routing it to whichever stage is active.

## Interface
Parameters:
- `WIDTH_BITS`, 8, column address width of the result memory.
- `HEIGHT_BITS`, 8, row address width of the result memory.
- `TIMEOUT_CYCLES`, 2097152, per-stage cycle limit; used only with `SEQ_TIMEOUT_EN`.

Ports:
- `clock`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request, sampled each clock; accepted only in IDLE, DONE or ERROR.
- `global_state`  out  3  current stage: 0 IDLE, 1 BOX, 2 THRESH, 3 OUTPUT, 4 DONE, 7 ERROR.
- `stage_clear_n`  out  1  registered; drives `not_reset` of all stages.
- `box_finished`, `thr_finished`, `out_finished`  in  1 each  stage completion flags; level, held until the stage is cleared.
- `box_res_col` in `WIDTH_BITS`, `box_res_row` in `HEIGHT_BITS`, `box_res_data` in 8, `box_res_wren` in 1: box filter write port.
- `thr_res_col` in `WIDTH_BITS`, `thr_res_row` in `HEIGHT_BITS`: threshold read address.
- `mem_col` out `WIDTH_BITS`, `mem_row` out `HEIGHT_BITS`, `mem_data` out 8, `mem_wren` out 1: result memory port.
- `busy`  out  1  high in BOX, THRESH or OUTPUT.
- `done`  out  1  high in DONE.
- `error`  out  1  high in ERROR; constant 0 without `SEQ_TIMEOUT_EN`.

## Operation
- **State register:** the state register is `global_state` itself, with encodings as listed above.
- **IDLE / DONE / ERROR with `start` high:**
  - next state is BOX;
  - `stage_clear_n` is 0 for exactly the first BOX cycle, then 1.
- **BOX:** when `box_finished` is high and `stage_clear_n` is 1, next state is THRESH.
- **THRESH:** when `thr_finished` is high, next state is OUTPUT.
- **OUTPUT:** when `out_finished` is high, next state is DONE.
- **Finished flags:**
  - Only the active stage's flag is evaluated; stale flags from earlier stages are ignored.
  - All flags are ignored while `stage_clear_n` is 0.
- **`start` while busy:** ignored and not queued.
- **Memory mux (combinational from `global_state`):**
  - BOX passes all four `box_res_*` signals.
  - THRESH passes `thr_res_col`/`thr_res_row`, with `mem_data` 0 and `mem_wren` 0.
  - All other states drive all `mem_*` outputs to 0.
- **Last box write:** the box filter raises its final `wren` in the same cycle as `box_finished`. Because the transition is registered, that cycle is still BOX, so the final pixel is written.

## Timing
- **Reset values:** `global_state` 0, `stage_clear_n` 0, `busy` 0, `done` 0, `error` 0, `mem_*` 0. `stage_clear_n` goes to 1 at the first clock edge after reset deasserts.
- **Reset mid-run:** returns to IDLE immediately, asynchronously. `stage_clear_n` drops to 0 at once, so the stages are reset with the sequencer.
- **Start latency:** `start` high at edge N gives `global_state`=1 after N and `stage_clear_n`=0 for cycle N..N+1.
- **Stage latency:** a finished flag first high in cycle k gives the next state after the edge ending cycle k (1 cycle).
- **Mux latency:** zero (combinational).

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A 22-bit stage counter clears on every state entry and increments each cycle in BOX, THRESH and OUTPUT.
  - When the counter equals `TIMEOUT_CYCLES-1` and the active finished flag is low, the next state is ERROR.
  - If the finished flag is high in that same cycle, finished wins.
  - ERROR holds until `start`; `error` is high while in ERROR.
- `SEQ_TIMEOUT_EN` undefined: no counter, ERROR is unreachable, `error` is tied 0.

## Structure
- **Package `threshold_pkg`:**
  - state encodings `ST_IDLE`, `ST_BOX`, `ST_THRESH`, `ST_OUTPUT`, `ST_DONE`, `ST_ERROR`;
  - `GLOBAL_STATE_W`=3;
  - default `TIMEOUT_CYCLES`.
- **Sub-module `stage_watchdog`:** counter plus terminal-count compare, instantiated only under `SEQ_TIMEOUT_EN`.

## Test plan
- **Idle after reset:** reset pulse, then idle 5 cycles -> `global_state` 0, `stage_clear_n` 1, `mem_wren` 0, `done` 0.
- **Full run:**
  - Stimulus: `start` pulse; stub stages raise finished 40/20/30 cycles after enable.
  - Required: states 1->2->3->4 at exactly those cycles; `stage_clear_n` low one cycle.
  - Required: a box write at col 3 row 3 in the finished cycle appears on `mem_*`.
- **Stale flag:** `box_finished` held high in THRESH -> no skip to DONE; `start` during BOX ignored.
- **Reset mid-run:** reset asserted mid-BOX -> `global_state` 0 and `stage_clear_n` 0 with no clock edge.
- **Timeout:**
  - With `SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: `thr_finished` never rises -> ERROR 16 cycles after THRESH entry, `error`=1; then `start` -> BOX with `error`=0.
  - Finished and terminal count in the same cycle -> OUTPUT, not ERROR.
- **Rerun:** `start` in DONE -> BOX with a fresh clear pulse; second run completes identically.
